// File: rtl/lc3b_types.sv
// Shared types for the memory-port arbiter: FSM states and the captured request.
package lc3b_types;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_DATA_W = 16;
    localparam int ARB_MASK_W = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I,
        ARB_D
    } arb_state_t;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [ARB_MASK_W-1:0] wmask;
        logic [ARB_ADDR_W-1:0] address;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_req_reg.sv
// Load-enabled request register; holds the granted request for the whole transaction.
module mem_req_reg
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  mem_req_t req_in,
    output mem_req_t req_out
);

    mem_req_t req_q;
    mem_req_t req_d;

    always_comb begin
        req_d = req_q;
        if (load) begin
            req_d = req_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign req_out = req_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between CPU fetch (I) and data (D).
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic                i_resp,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_resp,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [DATA_W/8-1:0] pmem_wmask,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [DATA_W-1:0]   pmem_wdata,
    input  logic                pmem_resp,
    input  logic [DATA_W-1:0]   pmem_rdata
);

    arb_state_t state_q, state_d;
    logic       last_d_q, last_d_d;
    logic       load;
    mem_req_t   req_in;
    mem_req_t   req_q;
    logic       i_req, d_req;
    logic       grant_i, grant_d;
    logic       busy;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    // On conflict, D wins only if I was the last side served.
    assign grant_d = d_req & (~i_req | ~last_d_q);
    assign grant_i = i_req & ~grant_d;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        load     = 1'b0;
        req_in   = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_i) begin
                    state_d        = ARB_I;
                    last_d_d       = 1'b0;
                    load           = 1'b1;
                    req_in.read    = 1'b1;
                    req_in.wmask   = '1;
                    req_in.address = i_address;
                end else if (grant_d) begin
                    state_d        = ARB_D;
                    last_d_d       = 1'b1;
                    load           = 1'b1;
                    req_in.read    = d_read & ~d_write;
                    req_in.write   = d_write;
                    req_in.wmask   = d_wmask;
                    req_in.address = d_address;
                    req_in.wdata   = d_wdata;
                end
            end
            ARB_I, ARB_D: begin
                if (pmem_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    mem_req_reg u_req (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .req_in  (req_in),
        .req_out (req_q)
    );

    // Strobes are gated by state so an async reset drops them at once.
    assign busy         = (state_q != ARB_IDLE);
    assign pmem_read    = busy & req_q.read;
    assign pmem_write   = busy & req_q.write;
    assign pmem_wmask   = req_q.wmask;
    assign pmem_address = req_q.address;
    assign pmem_wdata   = req_q.wdata;

    assign i_resp  = (state_q == ARB_I) & pmem_resp;
    assign d_resp  = (state_q == ARB_D) & pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

endmodule
